sdram_cmd_arbiter: RTL and testbench

- Round-robin arbiter/sequencer that shares the SDRAM command interface (CMD[2:0] NOP/READA/WRITEA, ADDR, CMD_ACK handshake) between NREQ independent requesters, e.g. write-FIFO and read-FIFO ports.
- Sits between the port FIFOs and the SDRAM control interface.
- Holds off while initialisation is in progress.
- Guards each command with a watchdog timeout.

---
 rtl/sdram_arb_pkg.sv | 20 ++
 rtl/sdram_cmd_arbiter_rr_pick.sv | 43 ++++
 rtl/sdram_cmd_arbiter.sv | 154 +++++++++++++++
 tb/tb_sdram_cmd_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sdram_arb_pkg
// Shared types and constants for the SDRAM command arbiter and the SDRAM
// control interface.
//   arb_state_t : arbiter FSM state encoding (IDLE, ISSUE, GAP)
//   CMD_*       : command encodings on the CMD[2:0] bus
// ---------------------------------------------------------------------------
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  localparam logic [2:0] CMD_NOP    = 3'b000;
  localparam logic [2:0] CMD_READA  = 3'b001;
  localparam logic [2:0] CMD_WRITEA = 3'b010;

endpackage

// File: rtl/sdram_cmd_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority select. The search starts at
// (last+1) mod NREQ and wraps, so the most recently served index has the
// lowest priority.
// Ports:
//   req    in  NREQ  request vector
//   last   in  IDXW  index served most recently
//   winner out IDXW  selected index (0 when valid=0)
//   valid  out 1     at least one request present
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last,
  output logic [IDXW-1:0] winner,
  output logic            valid
);

  // Each requester gets a distance from the search start; the smallest
  // distance among active requesters wins. Indexing stays constant per
  // loop iteration, which keeps the select a flat compare tree.
  int best;
  int off;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    best   = NREQ;
    off    = 0;
    for (int i = 0; i < NREQ; i++) begin
      off = (i + NREQ - 1 - int'(last)) % NREQ;
      if (req[i] && (off < best)) begin
        best   = off;
        winner = IDXW'(i);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_cmd_arbiter
// Shares the SDRAM command interface between NREQ requesters using
// round-robin arbitration. Each command is guarded by a watchdog; a
// command that is never acknowledged is dropped and flagged in ERR.
//
// Handshake: a requester raises REQ[i] with REQ_WR[i]/REQ_ADDR[i] valid and
// keeps REQ[i] high until DONE[i]. Direction and address are captured on the
// grant edge only. The control interface sees CMD != NOP with ADDR stable
// and answers with a single-cycle CMD_ACK; the arbiter then drives a NOP for
// at least one cycle before the next command.
//
// Ports:
//   CLK, RESET_N  clock, async active-low reset
//   HOLD          blocks new grants (init sequencing)
//   REQ/REQ_WR    per-port request level / direction (1 = WRITEA)
//   REQ_ADDR      per-port address, port i at [i*ASIZE +: ASIZE]
//   CMD_ACK       command acknowledge from the control interface
//   CMD/ADDR      command bus and aligned address
//   GNT           one-hot, high while the port's command is outstanding
//   DONE          one-cycle pulse to the acknowledged port
//   BUSY          FSM not in IDLE
//   ERR/ERR_PORT  sticky timeout flag / first port that timed out
//   STATE         current FSM state (debug)
// ---------------------------------------------------------------------------
module sdram_cmd_arbiter
  import sdram_arb_pkg::*;
#(
  parameter  int ASIZE   = 23,
  parameter  int NREQ    = 4,
  parameter  int TIMEOUT = 1024,
  localparam int IDXW    = $clog2(NREQ)
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  HOLD,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ-1:0]       REQ_WR,
  input  logic [NREQ*ASIZE-1:0] REQ_ADDR,
  input  logic                  CMD_ACK,
  output logic [2:0]            CMD,
  output logic [ASIZE-1:0]      ADDR,
  output logic [NREQ-1:0]       GNT,
  output logic [NREQ-1:0]       DONE,
  output logic                  BUSY,
  output logic                  ERR,
  output logic [IDXW-1:0]       ERR_PORT,
  output logic [1:0]            STATE
);

  // Timer counts 0..TIMEOUT-1 and the command is dropped when it reaches
  // the last value, so it never wraps.
  localparam int             TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);

  arb_state_t       state;
  logic [IDXW-1:0]  last;
  logic [TW-1:0]    timer;

  logic [IDXW-1:0]  pick_idx;
  logic             pick_valid;
  logic [ASIZE-1:0] sel_addr;
  logic             sel_wr;
  logic [NREQ-1:0]  sel_gnt;

  assign STATE = state;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req    (REQ),
    .last   (last),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  // Per-winner operands captured on the grant edge.
  always_comb begin
    sel_addr = '0;
    sel_wr   = 1'b0;
    sel_gnt  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IDXW'(i)) begin
        sel_addr   = REQ_ADDR[i*ASIZE +: ASIZE];
        sel_wr     = REQ_WR[i];
        sel_gnt[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      CMD      <= CMD_NOP;
      ADDR     <= '0;
      GNT      <= '0;
      DONE     <= '0;
      BUSY     <= 1'b0;
      ERR      <= 1'b0;
      ERR_PORT <= '0;
      last     <= IDXW'(NREQ - 1);
      timer    <= '0;
    end else begin
      DONE <= '0;
      case (state)
        IDLE: begin
          if (!HOLD && pick_valid) begin
            CMD   <= sel_wr ? CMD_WRITEA : CMD_READA;
            ADDR  <= sel_addr;
            GNT   <= sel_gnt;
            last  <= pick_idx;
            timer <= '0;
            BUSY  <= 1'b1;
            state <= ISSUE;
          end
        end

        ISSUE: begin
          timer <= timer + 1'b1;
          if (CMD_ACK) begin
            DONE  <= GNT;
            CMD   <= CMD_NOP;
            GNT   <= '0;
            state <= GAP;
          end else if (timer == TIMER_LAST) begin
            // Abandon the command; the port keeps its rr slot (last == w).
            CMD   <= CMD_NOP;
            GNT   <= '0;
            ERR   <= 1'b1;
            if (!ERR) begin
              ERR_PORT <= last;
            end
            state <= GAP;
          end
        end

        GAP: begin
          // One guaranteed NOP cycle so CMD_ACK can return low.
          CMD   <= CMD_NOP;
          BUSY  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          CMD   <= CMD_NOP;
          GNT   <= '0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_cmd_arbiter
// Directed bench for sdram_cmd_arbiter (ASIZE=23, NREQ=4, TIMEOUT=16).
// Inputs change 1 ns after a rising edge; outputs are checked at that same
// point, i.e. after the edge has updated the registered outputs.
// ---------------------------------------------------------------------------
module tb_sdram_cmd_arbiter;
  import sdram_arb_pkg::*;

  localparam int ASIZE   = 23;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;
  localparam int IDXW    = $clog2(NREQ);

  // clock / reset
  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  hold;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       req_wr;
  logic [NREQ*ASIZE-1:0] req_addr;
  logic                  cmd_ack;
  logic [2:0]            cmd;
  logic [ASIZE-1:0]      addr;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic                  err;
  logic [IDXW-1:0]       err_port;
  logic [1:0]            state;

  always #5 clk = ~clk;

  sdram_cmd_arbiter #(
    .ASIZE   (ASIZE),
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK      (clk),
    .RESET_N  (reset_n),
    .HOLD     (hold),
    .REQ      (req),
    .REQ_WR   (req_wr),
    .REQ_ADDR (req_addr),
    .CMD_ACK  (cmd_ack),
    .CMD      (cmd),
    .ADDR     (addr),
    .GNT      (gnt),
    .DONE     (done),
    .BUSY     (busy),
    .ERR      (err),
    .ERR_PORT (err_port),
    .STATE    (state)
  );

  int errors = 0;
  int checks = 0;

  // driver helpers
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_addr(input int port, input logic [ASIZE-1:0] a);
    req_addr[port*ASIZE +: ASIZE] = a;
  endtask

  // scoreboard compare
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // safety net: the sequence below is fixed-length, this only fires on a hang
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench time limit");
  end

  int exp_order [5] = '{1, 2, 3, 0, 1};

  initial begin
    reset_n  = 1'b0;
    hold     = 1'b0;
    req      = '0;
    req_wr   = '0;
    req_addr = '0;
    cmd_ack  = 1'b0;

    // ---------------- reset state ----------------
    tick(2);
    check("rst_cmd",      32'(cmd),      32'h0);
    check("rst_addr",     32'(addr),     32'h0);
    check("rst_gnt",      32'(gnt),      32'h0);
    check("rst_done",     32'(done),     32'h0);
    check("rst_busy",     32'(busy),     32'h0);
    check("rst_err",      32'(err),      32'h0);
    check("rst_err_port", 32'(err_port), 32'h0);
    check("rst_state",    32'(state),    32'(IDLE));
    reset_n = 1'b1;
    tick(1);
    check("idle_cmd", 32'(cmd), 32'h0);

    // ---------------- single port write ----------------
    req    = 4'b0001;
    req_wr = 4'b0001;
    set_addr(0, 23'h000100);
    tick(1);
    check("sp_cmd",   32'(cmd),   32'h2);
    check("sp_addr",  32'(addr),  32'h000100);
    check("sp_gnt",   32'(gnt),   32'h1);
    check("sp_busy",  32'(busy),  32'h1);
    check("sp_state", 32'(state), 32'(ISSUE));
    // operands are captured at grant only
    req_wr = 4'b0000;
    set_addr(0, 23'h7ABCDE);
    tick(1);
    check("sp_hold_cmd",  32'(cmd),  32'h2);
    check("sp_hold_addr", 32'(addr), 32'h000100);
    tick(1);
    check("sp_nodone", 32'(done), 32'h0);
    cmd_ack = 1'b1;
    tick(1);
    cmd_ack = 1'b0;
    req     = 4'b0000;
    check("sp_done",      32'(done),  32'h1);
    check("sp_gap_cmd",   32'(cmd),   32'h0);
    check("sp_gap_gnt",   32'(gnt),   32'h0);
    check("sp_gap_state", 32'(state), 32'(GAP));
    check("sp_gap_busy",  32'(busy),  32'h1);
    tick(1);
    check("sp_idle_done",  32'(done),  32'h0);
    check("sp_idle_busy",  32'(busy),  32'h0);
    check("sp_idle_state", 32'(state), 32'(IDLE));

    // ---------------- fairness (last=0, so order 1,2,3,0,1) ----------------
    req    = 4'b1111;
    req_wr = 4'b0000;
    for (int p = 0; p < NREQ; p++) set_addr(p, 23'(32'h1000 + p));
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check("rr_gnt",  32'(gnt),  32'(1 << exp_order[k]));
      check("rr_cmd",  32'(cmd),  32'h1);
      check("rr_addr", 32'(addr), 32'h1000 + 32'(exp_order[k]));
      cmd_ack = 1'b1;
      tick(1);
      cmd_ack = 1'b0;
      check("rr_done", 32'(done), 32'(1 << exp_order[k]));
      tick(1);
      check("rr_gap_cmd", 32'(cmd), 32'h0);
    end
    req = 4'b0000;
    tick(1);

    // ---------------- HOLD blocks grants ----------------
    hold   = 1'b1;
    req    = 4'b0100;
    req_wr = 4'b0000;
    set_addr(2, 23'h0ABCDE);
    for (int k = 0; k < 50; k++) begin
      tick(1);
      check("hold_cmd", 32'(cmd), 32'h0);
      check("hold_gnt", 32'(gnt), 32'h0);
    end
    hold = 1'b0;
    tick(1);
    check("hold_rel_cmd",  32'(cmd),  32'h1);
    check("hold_rel_gnt",  32'(gnt),  32'h4);
    check("hold_rel_addr", 32'(addr), 32'h0ABCDE);
    // HOLD rising mid-command does not abort it
    hold = 1'b1;
    tick(1);
    check("hold_mid_cmd", 32'(cmd), 32'h1);
    hold    = 1'b0;
    cmd_ack = 1'b1;
    tick(1);
    cmd_ack = 1'b0;
    req     = 4'b0000;
    check("hold_done", 32'(done), 32'h4);
    tick(1);

    // ---------------- timeout on port 2 (last=2) ----------------
    req    = 4'b0100;
    req_wr = 4'b0100;
    set_addr(2, 23'h000222);
    tick(1);
    check("to_gnt", 32'(gnt), 32'h4);
    check("to_cmd", 32'(cmd), 32'h2);
    tick(15);
    check("to_still_cmd", 32'(cmd), 32'h2);
    check("to_still_err", 32'(err), 32'h0);
    tick(1);
    check("to_cmd_nop",  32'(cmd),      32'h0);
    check("to_gnt_off",  32'(gnt),      32'h0);
    check("to_no_done",  32'(done),     32'h0);
    check("to_err",      32'(err),      32'h1);
    check("to_err_port", 32'(err_port), 32'h2);
    check("to_state",    32'(state),    32'(GAP));
    req    = 4'b1100;
    req_wr = 4'b0000;
    set_addr(3, 23'h000333);
    tick(2);
    check("to_next_gnt",  32'(gnt),  32'h8);
    check("to_next_addr", 32'(addr), 32'h000333);
    // second timeout must not overwrite ERR_PORT
    tick(16);
    check("to2_cmd",      32'(cmd),      32'h0);
    check("to2_err",      32'(err),      32'h1);
    check("to2_err_port", 32'(err_port), 32'h2);
    req = 4'b0000;
    tick(1);
    check("to2_idle", 32'(state), 32'(IDLE));

    // ---------------- spurious ack in IDLE and GAP (last=3) ----------------
    cmd_ack = 1'b1;
    tick(1);
    cmd_ack = 1'b0;
    check("sp_idle_ack_done",  32'(done),  32'h0);
    check("sp_idle_ack_state", 32'(state), 32'(IDLE));
    req = 4'b0001;
    tick(1);
    check("late_gnt", 32'(gnt), 32'h1);
    cmd_ack = 1'b1;
    tick(1);
    req = 4'b0000;
    check("late_done", 32'(done), 32'h1);
    tick(1);
    cmd_ack = 1'b0;
    check("gap_ack_done",  32'(done),  32'h0);
    check("gap_ack_state", 32'(state), 32'(IDLE));
    check("gap_ack_cmd",   32'(cmd),   32'h0);

    // ---------------- reset mid-ISSUE (last=0 -> port 1) ----------------
    req = 4'b0010;
    set_addr(1, 23'h000111);
    tick(1);
    check("mr_gnt", 32'(gnt), 32'h2);
    reset_n = 1'b0;
    #1;
    check("mr_cmd",  32'(cmd),  32'h0);
    check("mr_gnt0", 32'(gnt),  32'h0);
    check("mr_busy", 32'(busy), 32'h0);
    check("mr_err",  32'(err),  32'h0);
    tick(1);
    reset_n = 1'b1;
    tick(1);
    check("mr_regnt",    32'(gnt),  32'h2);
    check("mr_recmd",    32'(cmd),  32'h1);
    check("mr_readdr",   32'(addr), 32'h000111);
    // REQ dropping mid-command still yields DONE
    req = 4'b0000;
    tick(1);
    cmd_ack = 1'b1;
    tick(1);
    cmd_ack = 1'b0;
    check("mr_done", 32'(done), 32'h2);
    tick(2);
    check("end_state", 32'(state), 32'(IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
